// File: rtl/carry_resolve_packer.sv
// Carry-resolving byte packer: holds one byte plus a run of 0xFF bytes until a carry or a
// non-FF byte settles them, then streams settled bytes through a FWFT FIFO. CRP_BYTE_COUNT_EN
// adds the out_byte_count pop counter.
module carry_resolve_packer #(
  parameter int unsigned MAX_BYTES  = 2,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned RUN_W      = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   top_clk,
  input  logic                   top_reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*MAX_BYTES-1:0] in_data,
  input  logic [CNT_W-1:0]       in_count,
  input  logic                   in_carry,
  input  logic                   in_final,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   out_last,
`ifdef CRP_BYTE_COUNT_EN
  output logic [31:0]            out_byte_count,
`endif
  output logic                   err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StCarry, StZrun, StByte, StEmit, StFlush} state_e;

  state_e                 state_q;
  logic [8*MAX_BYTES-1:0] data_q;
  logic [CNT_W-1:0]       count_q, idx_q, idx_next;
  logic                   final_q;
  logic [7:0]             hold_q, cur_byte;
  logic                   hold_v_q, err_q;
  logic [RUN_W-1:0]       run_q;
  logic [AW:0]            wptr_q, rptr_q, fifo_cnt;
  logic [8:0]             mem [FIFO_DEPTH];
  logic                   full, pop, push_req, push_en, push_last, pend_last;
  logic [7:0]             push_byte;

  assign fifo_cnt  = wptr_q - rptr_q;
  assign full      = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign out_valid = (wptr_q != rptr_q);
  assign pop       = out_valid & out_ready;
  assign out_byte  = mem[rptr_q[AW-1:0]][7:0];
  assign out_last  = out_valid & mem[rptr_q[AW-1:0]][8];
  assign in_ready  = (state_q == StIdle);
  assign err       = err_q;
  assign idx_next  = idx_q + 1'b1;
  // True when the push this cycle drains the last pending byte (hold, or final 0xFF of run).
  assign pend_last = hold_v_q ? (run_q == '0) : (run_q == RUN_W'(1));

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (idx_q == CNT_W'(i)) cur_byte = data_q[8*(int'(MAX_BYTES)-1-i) +: 8];
    end
  end

  always_comb begin
    push_req  = 1'b0;
    push_byte = '0;
    push_last = 1'b0;
    case (state_q)
      StCarry: begin
        push_req  = 1'b1;
        push_byte = hold_q + 8'd1;
      end
      StZrun: push_req = 1'b1;
      StEmit: begin
        push_req  = 1'b1;
        push_byte = hold_v_q ? hold_q : 8'hFF;
      end
      StFlush: begin
        push_req  = hold_v_q | (run_q != '0);
        push_byte = hold_v_q ? hold_q : 8'hFF;
        push_last = pend_last;
      end
      default: ;
    endcase
  end

  assign push_en = push_req & ~full;

  function automatic state_e step_after(input logic [CNT_W-1:0] nidx);
    if (nidx != count_q) return StByte;
    else if (final_q)    return StFlush;
    else                 return StIdle;
  endfunction

  always_ff @(posedge top_clk) begin
    if (push_en) mem[wptr_q[AW-1:0]] <= {push_last, push_byte};
  end

  always_ff @(posedge top_clk) begin
    if (top_reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      final_q  <= 1'b0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      run_q    <= '0;
      err_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      unique case (state_q)
        StIdle: if (in_valid) begin
          data_q  <= in_data;
          count_q <= in_count;
          final_q <= in_final;
          idx_q   <= '0;
          if (in_carry && !hold_v_q) err_q <= 1'b1;
          if (in_carry && hold_v_q)  state_q <= StCarry;
          else if (in_count != '0)   state_q <= StByte;
          else if (in_final)         state_q <= StFlush;
        end
        StCarry: if (!full) begin
          hold_v_q <= 1'b0;
          state_q  <= (run_q != '0) ? StZrun : step_after(idx_q);
        end
        StZrun: if (!full) begin
          run_q <= run_q - 1'b1;
          if (run_q == RUN_W'(1)) state_q <= step_after(idx_q);
        end
        StByte: begin
          if (!hold_v_q) begin
            hold_q   <= cur_byte;
            hold_v_q <= 1'b1;
            idx_q    <= idx_next;
            state_q  <= step_after(idx_next);
          end else if (cur_byte == 8'hFF) begin
            if (run_q == '1) err_q <= 1'b1;
            else             run_q <= run_q + 1'b1;
            idx_q   <= idx_next;
            state_q <= step_after(idx_next);
          end else begin
            state_q <= StEmit;
          end
        end
        StEmit: if (!full) begin
          if (hold_v_q) hold_v_q <= 1'b0;
          else          run_q    <= run_q - 1'b1;
          // The new byte becomes hold in the same cycle as the last displaced push.
          if (pend_last) begin
            hold_q   <= cur_byte;
            hold_v_q <= 1'b1;
            idx_q    <= idx_next;
            state_q  <= step_after(idx_next);
          end
        end
        StFlush: begin
          if (!push_req) begin
            state_q <= StIdle;
          end else if (!full) begin
            if (hold_v_q) hold_v_q <= 1'b0;
            else          run_q    <= run_q - 1'b1;
            if (push_last) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CRP_BYTE_COUNT_EN
  logic [31:0] byte_cnt_q;
  assign out_byte_count = byte_cnt_q;

  always_ff @(posedge top_clk) begin
    if (top_reset)     byte_cnt_q <= '0;
    else if (pop)      byte_cnt_q <= out_last ? 32'd0 : byte_cnt_q + 32'd1;
  end
`endif

endmodule
